// File: rtl/link_failover.sv
`default_nettype none
// ============================================================================
// Module   : link_failover
// Brief    : Redundant-link selector. Debounces per-link health, selects the
//            lowest-index qualified link, and walks through a fixed holdoff
//            window with pre/post switch pulses whenever the selection drops.
// Revision : 1.0 - initial release
// ============================================================================
module link_failover #(
    parameter int NUM_LINKS = 2,
    parameter int HOLDOFF   = 4_000_000,
    parameter int DEBOUNCE  = 16,
    parameter int PULSE_LEN = 15,
    parameter int REVERTIVE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LINKS-1:0]         link_ok,
    output logic [NUM_LINKS-1:0]         link_enable,
    output logic [$clog2(NUM_LINKS)-1:0] active_sel,
    output logic                         active_valid,
    output logic                         pre_switch,
    output logic                         post_switch,
    output logic [15:0]                  switch_count
);

    localparam int          SEL_W       = $clog2(NUM_LINKS);
    localparam logic [8:0]  c_DEB       = 9'(DEBOUNCE);
    localparam logic [23:0] c_HOLD_LAST = 24'(HOLDOFF - 1);
    localparam logic [7:0]  c_PULSE     = 8'(PULSE_LEN);

    typedef enum logic [1:0] {
        c_IDLE    = 2'd0,
        c_ACTIVE  = 2'd1,
        c_HOLDOFF = 2'd2
    } state_t;

    // Qualified (debounced) health, one bit per link.
    logic [NUM_LINKS-1:0] w_qual;

    // ------------------------------------------------------------------
    // Per-link debounce: count consecutive high samples; qualify on the
    // DEBOUNCE-th, drop immediately on any low sample.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_link
        logic [7:0] r_cnt_q;
        logic [7:0] w_cnt_d;
        logic       r_qual_q;
        logic       w_qual_d;

        // Next-state of the run-length counter and qualified flag.
        always_comb begin
            w_cnt_d  = r_cnt_q;
            w_qual_d = r_qual_q;
            if (!link_ok[gi]) begin
                w_cnt_d  = 8'd0;
                w_qual_d = 1'b0;
            end else if (!r_qual_q) begin
                if (({1'b0, r_cnt_q} + 9'd1) >= c_DEB) begin
                    w_qual_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
            end
        end

        // Debounce state registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt_q  <= 8'd0;
                r_qual_q <= 1'b0;
            end else begin
                r_cnt_q  <= w_cnt_d;
                r_qual_q <= w_qual_d;
            end
        end

        assign w_qual[gi] = r_qual_q;
    end

    // Registered state and outputs.
    state_t                r_state_q,   w_state_d;
    logic [SEL_W-1:0]      r_sel_q,     w_sel_d;
    logic [23:0]           r_timer_q,   w_timer_d;
    logic [7:0]            r_pre_cnt_q, w_pre_cnt_d;
    logic [7:0]            r_post_cnt_q, w_post_cnt_d;
    logic [15:0]           r_count_q,   w_count_d;
    logic [NUM_LINKS-1:0]  r_enable_q,  w_enable_d;
    logic                  r_valid_q,   w_valid_d;
    logic                  r_pre_q,     w_pre_d;
    logic                  r_post_q,    w_post_d;

    logic [SEL_W-1:0]      w_first;
    logic                  w_revert;
    logic                  w_pre_trig;
    logic                  w_post_trig;

    // Selection helpers: lowest qualified index and revert condition.
    always_comb begin
        w_first  = '0;
        w_revert = 1'b0;
        for (int i = NUM_LINKS - 1; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_first = SEL_W'(i);
            end
        end
        for (int j = 0; j < NUM_LINKS; j++) begin
            if ((REVERTIVE != 0) && (j < int'(r_sel_q)) && w_qual[j]) begin
                w_revert = 1'b1;
            end
        end
    end

    // FSM next state, pulse counters and registered-output next values.
    always_comb begin
        w_state_d   = r_state_q;
        w_sel_d     = r_sel_q;
        w_timer_d   = r_timer_q;
        w_count_d   = r_count_q;
        w_pre_trig  = 1'b0;
        w_post_trig = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                if (|w_qual) begin
                    w_state_d = c_ACTIVE;
                    w_sel_d   = w_first;
                    w_count_d = (r_count_q == 16'hFFFF) ? r_count_q : r_count_q + 16'd1;
                end
            end
            c_ACTIVE: begin
                // A failure and a revert on the same cycle collapse into one entry.
                if (!w_qual[r_sel_q] || w_revert) begin
                    w_state_d  = c_HOLDOFF;
                    w_sel_d    = '0;
                    w_timer_d  = 24'd0;
                    w_pre_trig = 1'b1;
                end
            end
            c_HOLDOFF: begin
                if (r_timer_q == c_HOLD_LAST) begin
                    w_state_d   = c_IDLE;
                    w_timer_d   = 24'd0;
                    w_post_trig = 1'b1;
                end else begin
                    w_timer_d = r_timer_q + 24'd1;
                end
            end
            default: begin
                w_state_d = c_IDLE;
                w_sel_d   = '0;
                w_timer_d = 24'd0;
            end
        endcase

        // Retrigger reloads the full length.
        if (w_pre_trig) begin
            w_pre_cnt_d = c_PULSE;
        end else if (r_pre_cnt_q != 8'd0) begin
            w_pre_cnt_d = r_pre_cnt_q - 8'd1;
        end else begin
            w_pre_cnt_d = r_pre_cnt_q;
        end

        if (w_post_trig) begin
            w_post_cnt_d = c_PULSE;
        end else if (r_post_cnt_q != 8'd0) begin
            w_post_cnt_d = r_post_cnt_q - 8'd1;
        end else begin
            w_post_cnt_d = r_post_cnt_q;
        end

        w_valid_d = (w_state_d == c_ACTIVE);
        w_pre_d   = (w_pre_cnt_d != 8'd0);
        w_post_d  = (w_post_cnt_d != 8'd0);
        for (int k = 0; k < NUM_LINKS; k++) begin
            w_enable_d[k] = (w_state_d == c_ACTIVE) && (w_sel_d == SEL_W'(k));
        end
    end

    // State, timer, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_IDLE;
            r_sel_q      <= '0;
            r_timer_q    <= 24'd0;
            r_pre_cnt_q  <= 8'd0;
            r_post_cnt_q <= 8'd0;
            r_count_q    <= 16'd0;
            r_enable_q   <= '0;
            r_valid_q    <= 1'b0;
            r_pre_q      <= 1'b0;
            r_post_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_sel_q      <= w_sel_d;
            r_timer_q    <= w_timer_d;
            r_pre_cnt_q  <= w_pre_cnt_d;
            r_post_cnt_q <= w_post_cnt_d;
            r_count_q    <= w_count_d;
            r_enable_q   <= w_enable_d;
            r_valid_q    <= w_valid_d;
            r_pre_q      <= w_pre_d;
            r_post_q     <= w_post_d;
        end
    end

    assign link_enable  = r_enable_q;
    assign active_sel   = r_sel_q;
    assign active_valid = r_valid_q;
    assign pre_switch   = r_pre_q;
    assign post_switch  = r_post_q;
    assign switch_count = r_count_q;

endmodule
`default_nettype wire
